// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the sequential 8x8 multiplier.
package mul_pkg;

  localparam int WIDTH = 8;
  localparam int ITERS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fadder8.sv
// 8-bit ripple-carry adder used as the add stage of the shift-and-add multiplier.
module fadder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[8];

endmodule

// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 unsigned shift-and-add multiplier with valid/ready on both sides.
// One fadder8 is reused once per multiplier bit; result is {A,Q} after 8 iterations.
module mul8_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  import mul_pkg::*;

  state_e             state_q, state_d, state_dec;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic               c_n;
  logic [WIDTH-1:0]   a_n;

  fadder8 u_add (
    .a    (a_q),
    .b    (m_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // The unused encoding 2'd3 is folded onto IDLE so the FSM always recovers.
  always_comb begin
    case (state_q)
      IDLE, RUN, DONE: state_dec = state_q;
      default:         state_dec = IDLE;
    endcase
  end

  always_comb begin
    state_d     = state_dec;
    a_d         = a_q;
    q_d         = q_q;
    m_d         = m_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    {c_n, a_n}  = q_q[0] ? {add_cout, add_sum} : {1'b0, a_q};

    case (state_dec)
      IDLE: begin
        out_valid_d = 1'b0;
        if (in_valid) begin
          m_d     = in_a;
          q_d     = in_b;
          a_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Carry-out is kept: it becomes the new A msb on the right shift.
        a_d   = {c_n, a_n[WIDTH-1:1]};
        q_d   = {a_n[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      m_q         <= m_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_dec == IDLE);
  assign busy      = (state_dec == RUN) || (state_dec == DONE);
  assign out_valid = out_valid_q;
  assign out_p     = {a_q, q_q};

endmodule
